// File: rtl/seg_scroll_display.sv
// Scrolling N_DIGITS-wide seven-segment window over a nibble ROM, with tick divider, run/pause and single-step.
// Optional decimal-point start marker enabled by defining SEG_DP_MARK_EN.
module seg_scroll_display #(
  parameter int          N_DIGITS = 4,
  parameter int          DEPTH    = 8,
  parameter int          DIV_MAX  = 25000000,
  parameter logic [63:0] ROM_INIT = 64'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       dir,
  input  logic                       step,
  output logic [N_DIGITS*7-1:0]      seg,
  output logic [$clog2(DEPTH)-1:0]   pos,
  output logic                       tick
`ifdef SEG_DP_MARK_EN
  ,
  output logic [N_DIGITS-1:0]        dp
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DIV_MAX);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_MAX - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(DEPTH - 1);
  localparam logic [PW:0]   DEPTH_W  = (PW + 1)'(DEPTH);

  function automatic int off_mod(input int off);
    int r;
    r = off;
    for (int j = 0; j < 8; j++) begin
      if (r >= DEPTH) r = r - DEPTH;
    end
    return r;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Divider only runs while run=1; dropping run re-arms it from zero.
  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (!run || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign tick = run && (div_cnt == DIV_LAST);

  logic step_meta, step_sync, step_prev;
  logic step_pulse, advance;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_meta <= 1'b0;
      step_sync <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      step_meta <= step;
      step_sync <= step_meta;
      step_prev <= step_sync;
    end
  end

  assign step_pulse = step_sync && !step_prev;
  assign advance    = run ? tick : step_pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos <= '0;
    end else if (advance) begin
      if (dir) pos <= (pos == '0) ? POS_LAST : pos - PW'(1);
      else     pos <= (pos == POS_LAST) ? '0 : pos + PW'(1);
    end
  end

  logic [3:0] rom [DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom[k] = ROM_INIT[4*k +: 4];
  end

  logic [N_DIGITS*7-1:0] seg_nxt;
  logic [N_DIGITS-1:0]   dp_nxt;

  // Offsets are reduced at elaboration, so one conditional subtract keeps each address in range.
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    localparam int OFF = off_mod(N_DIGITS - 1 - i);
    logic [PW:0] sum;
    logic [PW:0] addr;
    assign sum  = {1'b0, pos} + (PW + 1)'(OFF);
    assign addr = (sum >= DEPTH_W) ? sum - DEPTH_W : sum;
    assign seg_nxt[7*i +: 7] = hex7(rom[addr[PW-1:0]]);
    assign dp_nxt[i]         = (addr != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= '1;
    end else begin
      seg <= seg_nxt;
    end
  end

`ifdef SEG_DP_MARK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp <= '1;
    end else begin
      dp <= dp_nxt;
    end
  end
`else
  logic dp_unused;
  assign dp_unused = ^dp_nxt;
`endif

endmodule

// File: tb/tb_seg_scroll_display.sv
// Bench for seg_scroll_display: randomized run/dir/step stimulus against a window/decode reference model.
module tb_seg_scroll_display;

  localparam int ND = 4;
  localparam int DP = 8;
  localparam int DM = 4;
  localparam logic [63:0] RI = 64'h0000_0000_3210_5011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic dir = 1'b0;
  logic step = 1'b0;
  logic [ND*7-1:0] seg;
  logic [2:0] pos;
  logic tick;
`ifdef SEG_DP_MARK_EN
  logic [ND-1:0] dp;
`endif

  seg_scroll_display #(
    .N_DIGITS(ND), .DEPTH(DP), .DIV_MAX(DM), .ROM_INIT(RI)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .dir(dir), .step(step),
    .seg(seg), .pos(pos), .tick(tick)
`ifdef SEG_DP_MARK_EN
    , .dp(dp)
`endif
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total = 0;
  int rom_m [8] = '{1, 1, 0, 5, 0, 1, 2, 3};
  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int m_pos = 0;
  int prev_pos = 0;
  int k = 0;

  function automatic logic [ND*7-1:0] window(input int p);
    logic [ND*7-1:0] w;
    for (int i = 0; i < ND; i++) w[7*i +: 7] = dec[rom_m[(p + ND - 1 - i) % DP]];
    return w;
  endfunction

  function automatic logic [ND-1:0] dp_model(input int p);
    logic [ND-1:0] d;
    for (int i = 0; i < ND; i++) d[i] = ((p + ND - 1 - i) % DP) != 0;
    return d;
  endfunction

  function automatic int next_pos(input int p, input logic d);
    return d ? (p + DP - 1) % DP : (p + 1) % DP;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock with inputs already driven: tick before the edge, pos/seg after it.
  task automatic run_cycle(input string tag);
    logic exp_tick;
    #1;
    exp_tick = run && (k % DM == DM - 1);
    check({tag, "/tick"}, 64'(tick), 64'(exp_tick));
    @(posedge clk);
    prev_pos = m_pos;
    if (exp_tick) m_pos = next_pos(m_pos, dir);
    k = run ? k + 1 : 0;
    @(negedge clk);
    check({tag, "/pos"}, 64'(pos), 64'(m_pos));
    check({tag, "/seg"}, 64'(seg), 64'(window(prev_pos)));
`ifdef SEG_DP_MARK_EN
    check({tag, "/dp"}, 64'(dp), 64'(dp_model(prev_pos)));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst/pos", 64'(pos), 64'd0);
    check("rst/seg", 64'(seg), 64'hFFF_FFFF);
    check("rst/tick", 64'(tick), 64'd0);
`ifdef SEG_DP_MARK_EN
    check("rst/dp", 64'(dp), 64'hF);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_pos = 0;
    prev_pos = 0;
    k = 0;
  endtask

  task automatic step_test(input int width, input int gap, input logic d);
    int seen;
    int exp;
    seen = 0;
    dir = d;
    exp = next_pos(m_pos, d);
    step = 1'b1;
    for (int c = 1; c <= width + gap; c++) begin
      @(negedge clk);
      #1;
      check("step/tick", 64'(tick), 64'd0);
      if (seen == 0 && pos == 3'(exp)) seen = c;
      if (c == width) step = 1'b0;
    end
    check("step/latency_ok", 64'(seen >= 2 && seen <= 3), 64'd1);
    check("step/pos", 64'(pos), 64'(exp));
    check("step/seg", 64'(seg), 64'(window(exp)));
    m_pos = exp;
    prev_pos = exp;
    k = 0;
  endtask

  initial begin
    logic found;
    #3;
    do_reset();

    run_cycle("idle");
    check("first_window", 64'(seg), 64'({7'h79, 7'h79, 7'h40, 7'h12}));

    run = 1'b1;
    dir = 1'b0;
    for (int c = 0; c < 36; c++) begin
      run_cycle("fwd");
      if (prev_pos == 6) begin
        check("wrap_window", 64'(seg), 64'({7'h24, 7'h30, 7'h79, 7'h79}));
`ifdef SEG_DP_MARK_EN
        check("dp_pos6", 64'(dp), 64'(4'b1101));
`endif
      end
    end

    run = 1'b0;
    do_reset();
    run = 1'b1;
    dir = 1'b1;
    for (int c = 0; c < 4; c++) run_cycle("bwd");
    check("bwd_first_pos", 64'(pos), 64'd7);
    run_cycle("bwd");
    check("bwd_window", 64'(seg), 64'({7'h30, 7'h79, 7'h79, 7'h40}));

    for (int c = 0; c < 60; c++) begin
      run = ($urandom % 6) != 0;
      dir = 1'($urandom % 2);
      run_cycle("rand");
    end

    run = 1'b0;
    for (int c = 0; c < 3; c++) run_cycle("settle");
    for (int p = 0; p < 3; p++) step_test(10, 4 + $urandom_range(0, 4), 1'b0);
    for (int p = 0; p < 4; p++) step_test($urandom_range(1, 6), $urandom_range(4, 8), 1'($urandom % 2));

    run = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step = 1'($urandom % 2);
      dir = 1'($urandom % 2);
      run_cycle("run_step");
    end
    step = 1'b0;
    for (int c = 0; c < 4; c++) run_cycle("run_step");

    dir = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 80 && !found; c++) begin
      if (m_pos == 5 && k % DM == 2) found = 1'b1;
      else run_cycle("to_pos5");
    end
    check("reach_pos5", 64'(found), 64'd1);
    do_reset();
    run = 1'b0;
    run_cycle("post_rst");
    check("post_rst_window", 64'(seg), 64'({7'h79, 7'h79, 7'h40, 7'h12}));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/seg_scroll_display.md
Name: seg_scroll_display

Overview:
- Parametrised successor to the single-digit ROM/counter/7-seg display chain.
- Drives N_DIGITS seven-segment digits that show a sliding window over a DEPTH-entry nibble ROM.
- Has a built-in tick divider, run/pause, single-step, and scroll direction.
- Sits between board switches/buttons and the HEX displays in lab top-levels.

Parameters:
- N_DIGITS, 4, number of 7-seg digits driven (1..8).
- DEPTH, 8, number of ROM entries (2..16; need not be a power of 2).
- DIV_MAX, 25000000, clk cycles per scroll tick (>=2).
- ROM_INIT, 64'h0, packed DEPTH*4-bit contents; entry k = ROM_INIT[4k+3:4k].

Ports:
- clk, input, 1, system clock (50 MHz on board).
- reset, input, 1, asynchronous, active-low reset.
- run, input, 1, 1 = auto-scroll on divider tick; 0 = paused / step mode.
- dir, input, 1, 0 = forward (pos+1), 1 = backward (pos-1).
- step, input, 1, raw asynchronous pushbutton, active-high; advances one position when run=0.
- seg, output, N_DIGITS*7, active-low segments; digit i in seg[7i+6:7i], bit order {g,f,e,d,c,b,a}.
- pos, output, $clog2(DEPTH), current window start address.
- tick, output, 1, one-cycle pulse when the divider expires.

Behaviour:
- Reset (reset=0, async) forces:
  - pos=0, divider count=0, tick=0.
  - seg = all 1s (blank).
  - step synchroniser and edge registers = 0.
- Divider:
  - Counts 0..DIV_MAX-1 only while run=1.
  - tick=1 for exactly the cycle in which the count equals DIV_MAX-1; the count then wraps to 0.
  - While run=0 the count is held at 0 and tick=0.
  - When run goes 0->1, the first tick arrives DIV_MAX cycles later.
- step path:
  - 2-FF synchroniser, then a rising-edge detector giving a one-cycle step_pulse.
  - Latency from the step rising edge to step_pulse is 2-3 clk cycles.
- Advance event:
  - run=1: advance = tick.
  - run=0: advance = step_pulse.
  - step is ignored while run=1. tick cannot occur while run=0.
- On advance, dir is sampled in the same cycle:
  - Forward: pos = (pos==DEPTH-1) ? 0 : pos+1.
  - Backward: pos = (pos==0) ? DEPTH-1 : pos-1.
- Window mapping:
  - Digit i (i=0 is the rightmost digit) shows ROM[(pos + N_DIGITS-1-i) mod DEPTH].
  - The leftmost digit therefore shows ROM[pos].
  - If N_DIGITS > DEPTH, addresses wrap repeatedly.
  - The modulo is computed with compare/subtract; no divider hardware.
- Decoder (hex, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - A=08, b=03, C=46, d=21, E=06, F=0E.
- seg is registered:
  - It reflects pos one cycle after pos updates.
  - After reset release, the first valid window (pos=0) appears on the first clk edge.
- Changes to dir or run mid-count take effect on the next advance only; the divider count is not disturbed except by run=0.
- A reset asserted mid-scroll returns the block to pos=0 immediately; there is no partial step.

Optional Feature:
- Macro: SEG_DP_MARK_EN.
- Defined:
  - Adds output dp, width N_DIGITS, active-low, registered with seg.
  - dp[i]=0 when digit i is showing ROM address 0, marking the start of the sequence.
  - dp resets to all 1s.
- Undefined: no dp port; behaviour is otherwise identical.

Test Plan:
- Common settings: N_DIGITS=4, DEPTH=8, DIV_MAX=4, ROM_INIT entries 0..7 = 1,1,0,5,0,1,2,3.
- Reset then run=1, dir=0:
  - seg digits (left to right) = 1,1,0,5, i.e. 79,79,40,12.
  - tick every 4th cycle.
  - pos sequence 0,1,...,7,0.
  - At pos=6 the display shows 2,3,1,1 (wrap).
- run=1, dir=1 from pos=0: after the first tick pos=7 and the display shows 3,1,1,0.
- run=0, pulse step high for 10 cycles, three times:
  - pos advances by exactly 3.
  - tick stays 0.
  - Each advance occurs 2-3 cycles after the step rise.
- run=1 with step toggled continuously: pos changes only on tick, every 4 cycles.
- Assert reset asynchronously mid-divider at pos=5:
  - pos=0 and seg=all 1s immediately, without waiting for a clk edge.
  - After release the display shows 1,1,0,5.
- SEG_DP_MARK_EN defined, pos=6: dp = 4'b1101 (digit showing address 0 is low).
